// File: rtl/dmem_ctrl_if.sv
// Bus bundle between the M-stage data port, the data-memory controller and
// the backing RAM. The controller takes the slave view; the CPU/RAM side
// takes the master view.
interface dmem_if #(
  parameter int WBUF_DEPTH = 4
);
  localparam int CW = $clog2(WBUF_DEPTH) + 1;

  logic [31:0]   cpu_addr;
  logic [31:0]   cpu_wdata;
  logic          cpu_we;
  logic          cpu_re;
  logic [31:0]   cpu_rdata;
  logic          stall;
  logic [CW-1:0] wbuf_count;

  logic          mem_req;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ack;
  logic [31:0]   mem_rdata;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_we, cpu_re, mem_ack, mem_rdata,
    output cpu_rdata, stall, wbuf_count, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_we, cpu_re, mem_ack, mem_rdata,
    input  cpu_rdata, stall, wbuf_count, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_ctrl.sv
// M-stage data-memory controller: posts stores into an in-order write
// buffer, forwards buffered store data to loads, and issues a single RAM
// read per load miss. Loads jump ahead of queued stores but never ahead of
// a write that is already on the RAM bus.
module dmem_ctrl #(
  parameter int WBUF_DEPTH = 4
) (
  input  logic  clk,
  input  logic  reset,
  dmem_if.slave bus
);
  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WDRAIN, RD, RD_DONE} state_t;

  state_t        state_reg, state_next;

  // write buffer storage (no reset: only entries inside the count are read)
  logic [29:0]   wb_addr_reg [WBUF_DEPTH];
  logic [31:0]   wb_data_reg [WBUF_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;

  // registered RAM request and captured read data
  logic          mem_req_reg, mem_req_next;
  logic          mem_we_reg, mem_we_next;
  logic [29:0]   mem_addr_reg, mem_addr_next;
  logic [31:0]   mem_wdata_reg, mem_wdata_next;
  logic [31:0]   rdata_q_reg, rdata_q_next;

  logic [29:0]   cpu_word;
  logic          full, empty, load_req, hit, miss, push, pop, ack;
  logic [31:0]   hit_data;
  logic [29:0]   nhead_addr;
  logic [31:0]   nhead_data;
  logic          unused_addr_bits;

  assign cpu_word         = bus.cpu_addr[31:2];
  assign unused_addr_bits = ^bus.cpu_addr[1:0];
  assign full             = (count_reg == CW'(WBUF_DEPTH));
  assign empty            = (count_reg == '0);
  // a simultaneous store wins; the load half of such a request is dropped
  assign load_req         = bus.cpu_re && !bus.cpu_we;
  assign ack              = mem_req_reg && bus.mem_ack;
  assign pop              = ack && mem_we_reg;
  assign push             = bus.cpu_we && !full;

  // Forwarding search: walk from oldest to youngest so the youngest match wins
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int k = 0; k < WBUF_DEPTH; k++) begin
      if ((CW'(k) < count_reg) && (wb_addr_reg[rd_ptr_reg + PW'(k)] == cpu_word)) begin
        hit      = 1'b1;
        hit_data = wb_data_reg[rd_ptr_reg + PW'(k)];
      end
    end
  end

  // In RD_DONE the load is satisfied from rdata_q, so it is no longer a miss
  assign miss = load_req && !hit && (state_reg != RD_DONE);

  // CPU-facing outputs; both forced quiet while reset is asserted
  always_comb begin
    bus.stall     = !reset && (miss || (bus.cpu_we && full));
    bus.cpu_rdata = '0;
    if (!reset) begin
      if (state_reg == RD_DONE)
        bus.cpu_rdata = rdata_q_reg;
      else if (load_req && hit)
        bus.cpu_rdata = hit_data;
    end
  end

  assign bus.wbuf_count = count_reg;
  assign bus.mem_req    = mem_req_reg;
  assign bus.mem_we     = mem_we_reg;
  assign bus.mem_addr   = {mem_addr_reg, 2'b00};
  assign bus.mem_wdata  = mem_wdata_reg;

  // Entry that becomes head after the current pop; with a single entry left
  // it can only be the store being pushed at this very edge
  always_comb begin
    if (count_reg > CW'(1)) begin
      nhead_addr = wb_addr_reg[rd_ptr_reg + PW'(1)];
      nhead_data = wb_data_reg[rd_ptr_reg + PW'(1)];
    end else begin
      nhead_addr = cpu_word;
      nhead_data = bus.cpu_wdata;
    end
  end

  // Next-state and next RAM request
  always_comb begin
    state_next     = state_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    rdata_q_next   = rdata_q_reg;
    case (state_reg)
      IDLE: begin
        if (miss) begin
          state_next    = RD;
          mem_req_next  = 1'b1;
          mem_we_next   = 1'b0;
          mem_addr_next = cpu_word;
        end else if (!empty) begin
          state_next     = WDRAIN;
          mem_req_next   = 1'b1;
          mem_we_next    = 1'b1;
          mem_addr_next  = wb_addr_reg[rd_ptr_reg];
          mem_wdata_next = wb_data_reg[rd_ptr_reg];
        end
      end
      WDRAIN: begin
        if (ack) begin
          if (miss) begin
            state_next    = RD;
            mem_req_next  = 1'b1;
            mem_we_next   = 1'b0;
            mem_addr_next = cpu_word;
          end else if ((count_reg > CW'(1)) || push) begin
            mem_req_next   = 1'b1;
            mem_we_next    = 1'b1;
            mem_addr_next  = nhead_addr;
            mem_wdata_next = nhead_data;
          end else begin
            state_next   = IDLE;
            mem_req_next = 1'b0;
          end
        end
      end
      RD: begin
        if (ack) begin
          state_next   = RD_DONE;
          mem_req_next = 1'b0;
          rdata_q_next = bus.mem_rdata;
        end
      end
      RD_DONE: begin
        if (!empty) begin
          state_next     = WDRAIN;
          mem_req_next   = 1'b1;
          mem_we_next    = 1'b1;
          mem_addr_next  = wb_addr_reg[rd_ptr_reg];
          mem_wdata_next = wb_data_reg[rd_ptr_reg];
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, RAM request and read-data registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      rdata_q_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      rdata_q_reg   <= rdata_q_next;
    end
  end

  // Write-buffer pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Write-buffer entry storage
  always_ff @(posedge clk) begin
    if (push) begin
      wb_addr_reg[wr_ptr_reg] <= cpu_word;
      wb_data_reg[wr_ptr_reg] <= bus.cpu_wdata;
    end
  end

  // Simultaneous load and store from the pipeline is a CPU bug
  assert property (@(posedge clk) disable iff (reset) !(bus.cpu_we && bus.cpu_re))
    else $error("dmem_ctrl: cpu_we and cpu_re both asserted");

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: a RAM responder with programmable ack
// latency, a transaction log of completed RAM accesses, and a linear
// sequence of directed steps with hand-computed expectations.
module tb_dmem_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;

  dmem_if #(.WBUF_DEPTH(4)) mif ();

  dmem_ctrl #(.WBUF_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif.slave)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int stall_cnt = 0;

  // RAM model state
  logic [31:0] ram [logic [31:0]];
  logic [64:0] txlog [$];
  bit          ack_en = 1'b0;
  int          lat = 0;
  int          req_cyc = 0;

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 32'h0;
  endfunction

  // RAM responder: ack arrives in the (lat+1)-th cycle of each request
  always @(posedge clk) begin
    #1;
    if (reset) begin
      req_cyc = 0;
      mif.mem_ack = 1'b0;
      mif.mem_rdata = 32'h0;
    end else begin
      if (mif.mem_ack) req_cyc = 0;
      if (mif.mem_req && ack_en && req_cyc >= lat) begin
        mif.mem_ack = 1'b1;
        mif.mem_rdata = ram_rd(mif.mem_addr);
      end else begin
        mif.mem_ack = 1'b0;
      end
      if (mif.mem_req) req_cyc++;
      else req_cyc = 0;
    end
  end

  // Log every completed RAM transaction and apply writes to the model
  always @(posedge clk) begin
    if (!reset && mif.mem_req && mif.mem_ack) begin
      if (mif.mem_we) begin
        ram[mif.mem_addr] = mif.mem_wdata;
        txlog.push_back({1'b1, mif.mem_addr, mif.mem_wdata});
        $display("RAM write addr=%h data=%h", mif.mem_addr, mif.mem_wdata);
      end else begin
        txlog.push_back({1'b0, mif.mem_addr, mif.mem_rdata});
        $display("RAM read  addr=%h data=%h", mif.mem_addr, mif.mem_rdata);
      end
    end
  end

  always @(negedge clk) if (!reset && mif.stall) stall_cnt++;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic next();
    @(posedge clk);
    #2;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    mif.cpu_we = 1'b1; mif.cpu_re = 1'b0; mif.cpu_addr = a; mif.cpu_wdata = d;
  endtask

  task automatic load(input logic [31:0] a);
    mif.cpu_we = 1'b0; mif.cpu_re = 1'b1; mif.cpu_addr = a;
  endtask

  task automatic quiet();
    mif.cpu_we = 1'b0; mif.cpu_re = 1'b0;
  endtask

  // Bounded wait for the buffer to empty and the RAM bus to go idle
  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((mif.wbuf_count != 0 || mif.mem_req) && n < 60) begin
      next(); #1;
      n++;
    end
    check(tag, (mif.wbuf_count == 0 && !mif.mem_req), 1'b1);
  endtask

  // Bounded count of consecutive stall cycles starting with the current one
  task automatic count_stall(output int n);
    n = 0;
    while (mif.stall && n < 30) begin
      n++;
      next(); #1;
    end
  endtask

  int n;

  initial begin
    mif.cpu_addr = '0; mif.cpu_wdata = '0; mif.cpu_we = 1'b0; mif.cpu_re = 1'b0;
    mif.mem_ack = 1'b0; mif.mem_rdata = '0;
    ram[32'h40] = 32'hDEADBEEF;
    ram[32'h80] = 32'h0BADF00D;

    // ---- reset state, including a load request held during reset
    #2;
    check("rst_mem_req", mif.mem_req, 1'b0);
    check("rst_count",   mif.wbuf_count, 3'd0);
    load(32'h40);
    #1;
    check("rst_stall",   mif.stall, 1'b0);
    check("rst_rdata",   mif.cpu_rdata, 32'h0);
    quiet();
    next(); next();
    reset = 1'b0;
    #1;
    check("post_rst_stall", mif.stall, 1'b0);

    // ---- 1: three stores, ack in third request cycle
    ack_en = 1'b1; lat = 2; txlog.delete(); stall_cnt = 0;
    next(); store(32'h10, 32'hAAAA0001); #1; check("t1_s0_stall", mif.stall, 1'b0);
    next(); store(32'h14, 32'hAAAA0002); #1; check("t1_s1_stall", mif.stall, 1'b0);
    next(); store(32'h18, 32'hAAAA0003); #1; check("t1_s2_stall", mif.stall, 1'b0);
    next(); quiet(); #1;
    drain("t1_drain");
    check("t1_stall_cnt", stall_cnt, 0);
    check("t1_nwrites", txlog.size(), 3);
    check("t1_w0", txlog[0], {1'b1, 32'h10, 32'hAAAA0001});
    check("t1_w1", txlog[1], {1'b1, 32'h14, 32'hAAAA0002});
    check("t1_w2", txlog[2], {1'b1, 32'h18, 32'hAAAA0003});

    // ---- 2: five stores, RAM silent; fifth stalls until the first pop
    ack_en = 1'b0; lat = 0; txlog.delete();
    next(); store(32'h100, 32'h50); #1;
    next(); store(32'h104, 32'h51); #1;
    next(); store(32'h108, 32'h52); #1;
    next(); store(32'h10C, 32'h53); #1;
    next(); store(32'h110, 32'h54); #1;
    check("t2_full_count", mif.wbuf_count, 3'd4);
    check("t2_full_stall", mif.stall, 1'b1);
    next(); #1; check("t2_hold_stall", mif.stall, 1'b1);
    ack_en = 1'b1;
    next(); ack_en = 1'b0; #1;
    check("t2_ack_cycle_ack",   mif.mem_ack, 1'b1);
    check("t2_ack_cycle_stall", mif.stall, 1'b1);
    next(); #1;
    check("t2_after_pop_stall", mif.stall, 1'b0);
    check("t2_after_pop_count", mif.wbuf_count, 3'd3);
    next(); quiet(); #1;
    check("t2_enq5_count", mif.wbuf_count, 3'd4);
    ack_en = 1'b1;
    drain("t2_drain");
    check("t2_nwrites", txlog.size(), 5);
    check("t2_w4", txlog[4], {1'b1, 32'h110, 32'h54});

    // ---- 3: forwarding, youngest of two stores to the same word
    ack_en = 1'b0; txlog.delete();
    next(); store(32'h20, 32'h12345678); #1;
    next(); store(32'h20, 32'h0000BEEF); #1;
    next(); load(32'h20); #1;
    check("t3_fwd_rdata", mif.cpu_rdata, 32'h0000BEEF);
    check("t3_fwd_stall", mif.stall, 1'b0);
    next(); load(32'h22); #1;
    check("t3_fwd_lowbits", mif.cpu_rdata, 32'h0000BEEF);
    next(); quiet(); ack_en = 1'b1; lat = 0; #1;
    drain("t3_drain");

    // ---- 4: load miss, ack in third request cycle
    ack_en = 1'b1; lat = 2;
    next(); load(32'h40); #1;
    check("t4_first_stall", mif.stall, 1'b1);
    count_stall(n);
    check("t4_stall_cycles", n, 4);
    check("t4_rdata", mif.cpu_rdata, 32'hDEADBEEF);
    next(); quiet(); #1;
    check("t4_after_req", mif.mem_req, 1'b0);

    // ---- 5: load miss waits for in-flight write, overtakes queued one
    ack_en = 1'b1; lat = 2; txlog.delete();
    next(); store(32'h30, 32'h1); #1;
    next(); store(32'h34, 32'h2); #1;
    next(); load(32'h80); #1;
    check("t5_miss_stall", mif.stall, 1'b1);
    count_stall(n);
    check("t5_rdata", mif.cpu_rdata, 32'h0BADF00D);
    next(); quiet(); #1;
    drain("t5_drain");
    check("t5_ntx", txlog.size(), 3);
    check("t5_tx0", txlog[0], {1'b1, 32'h30, 32'h1});
    check("t5_tx1", txlog[1], {1'b0, 32'h80, 32'h0BADF00D});
    check("t5_tx2", txlog[2], {1'b1, 32'h34, 32'h2});

    // ---- 6: reset pulsed during RD
    ack_en = 1'b0;
    next(); load(32'hC0); #1;
    check("t6_miss_stall", mif.stall, 1'b1);
    next(); #1;
    check("t6_rd_req", mif.mem_req, 1'b1);
    reset = 1'b1;
    #1;
    check("t6_rst_req",   mif.mem_req, 1'b0);
    check("t6_rst_stall", mif.stall, 1'b0);
    check("t6_rst_count", mif.wbuf_count, 3'd0);
    check("t6_rst_rdata", mif.cpu_rdata, 32'h0);
    next(); quiet();
    next(); reset = 1'b0; #1;
    check("t6_rel_req", mif.mem_req, 1'b0);
    ack_en = 1'b1; lat = 1; txlog.delete();
    next(); store(32'h60, 32'h77); #1;
    check("t6_store_stall", mif.stall, 1'b0);
    next(); quiet(); #1;
    drain("t6_drain");
    check("t6_ntx", txlog.size(), 1);
    check("t6_tx0", txlog[0], {1'b1, 32'h60, 32'h77});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Hard bound on total runtime
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed %0d checks expected completion", total);
    $fatal(1, "timeout");
  end
endmodule
